// File: rtl/axis_width_adapter_pkg.sv
// Shared state type and elaboration helpers for the AXI4-Stream width adapter.
package axis_width_adapter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int eff_lanes(input int keep_enable, input int keep_width);
        return (keep_enable != 0) ? keep_width : 1;
    endfunction

    function automatic int seg_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_width_adapter_oreg.sv
// Output holding register with valid/ready; refills in the same cycle it drains.
module axis_width_adapter_oreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_payload,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_payload,
    input  logic         out_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready    = !valid_q || out_ready;
    assign out_valid   = valid_q;
    assign out_payload = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid && in_ready) begin
            valid_d = 1'b1;
            data_d  = in_payload;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axis_width_adapter.sv
// AXI4-Stream byte-lane width adapter (bypass / upsize / downsize).
// Define AXIS_WIDTH_ADAPTER_ID_DEST_EN to carry tid/tdest; otherwise they read as 0.
module axis_width_adapter
    import axis_width_adapter_pkg::*;
#(
    parameter int S_DATA_WIDTH  = 8,
    parameter int S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
    parameter int S_KEEP_WIDTH  = (S_DATA_WIDTH + 7) / 8,
    parameter int M_DATA_WIDTH  = 8,
    parameter int M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
    parameter int M_KEEP_WIDTH  = (M_DATA_WIDTH + 7) / 8,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_WIDTH    = 8,
    parameter int USER_ENABLE   = 1,
    parameter int USER_WIDTH    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int S_LANES = eff_lanes(S_KEEP_ENABLE, S_KEEP_WIDTH);
    localparam int M_LANES = eff_lanes(M_KEEP_ENABLE, M_KEEP_WIDTH);
    localparam int UPSIZE  = (M_LANES > S_LANES) ? 1 : 0;
    localparam int N       = UPSIZE ? (M_LANES / S_LANES) : (S_LANES / M_LANES);
    localparam int SEG_W   = seg_width(N);
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
    localparam int IDD_W   = ID_WIDTH + DEST_WIDTH;
`else
    localparam int IDD_W   = 0;
`endif
    localparam int PW      = M_DATA_WIDTH + M_LANES + 1 + USER_WIDTH + IDD_W;

    if ((S_DATA_WIDTH / S_LANES) != (M_DATA_WIDTH / M_LANES)) begin : g_err_byte
        $error("axis_width_adapter: byte size differs between input and output");
    end
    if ((UPSIZE != 0 && (M_LANES % S_LANES) != 0) || (UPSIZE == 0 && (S_LANES % M_LANES) != 0)) begin : g_err_ratio
        $error("axis_width_adapter: lane counts are not integer multiples");
    end

    logic                  unused_in;
    logic [S_LANES-1:0]    s_keep_eff;
    logic [USER_WIDTH-1:0] s_user_eff;

    assign unused_in  = ^{clk, rst_n, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser};
    assign s_user_eff = (USER_ENABLE != 0) ? s_axis_tuser : '0;

    if (S_KEEP_ENABLE != 0) begin : g_skeep
        assign s_keep_eff = s_axis_tkeep[S_LANES-1:0];
    end else begin : g_skeep_ones
        assign s_keep_eff = '1;
    end

    if (M_LANES == S_LANES) begin : g_bypass
        assign s_axis_tready = m_axis_tready;
        assign m_axis_tvalid = s_axis_tvalid;
        assign m_axis_tdata  = s_axis_tdata;
        assign m_axis_tlast  = s_axis_tlast;
        assign m_axis_tuser  = s_user_eff;
        if (M_KEEP_ENABLE != 0) begin : g_mkeep
            assign m_axis_tkeep = s_keep_eff;
        end else begin : g_mkeep_ones
            assign m_axis_tkeep = '1;
        end
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        assign m_axis_tid   = s_axis_tid;
        assign m_axis_tdest = s_axis_tdest;
`else
        assign m_axis_tid   = '0;
        assign m_axis_tdest = '0;
`endif
    end else begin : g_conv
        logic                    ready_en_q, ready_en_d;
        logic                    s_ready_core;
        logic                    in_valid, in_ready;
        logic [PW-1:0]           in_pl, out_pl;
        logic [M_DATA_WIDTH-1:0] in_data;
        logic [M_LANES-1:0]      in_keep, o_keep;
        logic                    in_last;
        logic [USER_WIDTH-1:0]   in_user, o_user;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        logic [ID_WIDTH-1:0]     in_id;
        logic [DEST_WIDTH-1:0]   in_dest;
        assign in_pl        = {in_data, in_keep, in_last, in_user, in_id, in_dest};
        assign m_axis_tid   = out_pl[DEST_WIDTH +: ID_WIDTH];
        assign m_axis_tdest = out_pl[0 +: DEST_WIDTH];
`else
        assign in_pl        = {in_data, in_keep, in_last, in_user};
        assign m_axis_tid   = '0;
        assign m_axis_tdest = '0;
`endif

        // Input stays closed until the first edge after reset release.
        assign ready_en_d    = 1'b1;
        assign s_axis_tready = s_ready_core;
        assign m_axis_tdata  = out_pl[PW-1 -: M_DATA_WIDTH];
        assign o_keep        = out_pl[PW-M_DATA_WIDTH-1 -: M_LANES];
        assign m_axis_tlast  = out_pl[USER_WIDTH + IDD_W];
        assign o_user        = out_pl[IDD_W +: USER_WIDTH];
        assign m_axis_tuser  = (USER_ENABLE != 0) ? o_user : '0;

        if (M_KEEP_ENABLE != 0) begin : g_mkeep
            assign m_axis_tkeep = o_keep;
        end else begin : g_mkeep_ones
            logic unused_keep;
            assign unused_keep  = ^o_keep;
            assign m_axis_tkeep = '1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ready_en_q <= 1'b0;
            else        ready_en_q <= ready_en_d;
        end

        axis_width_adapter_oreg #(.W(PW)) u_oreg (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_payload (in_pl),
            .in_ready   (in_ready),
            .out_valid  (m_axis_tvalid),
            .out_payload(out_pl),
            .out_ready  (m_axis_tready)
        );

        if (UPSIZE != 0) begin : g_up
            logic [M_DATA_WIDTH-1:0] acc_data_q, acc_data_d;
            logic [M_LANES-1:0]      acc_keep_q, acc_keep_d;
            logic [USER_WIDTH-1:0]   acc_user_q, acc_user_d;
            logic [SEG_W-1:0]        seg_q, seg_d;
            state_t                  state_q, state_d;
            logic                    take, closing;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
            logic [ID_WIDTH-1:0]     acc_id_q, acc_id_d;
            logic [DEST_WIDTH-1:0]   acc_dest_q, acc_dest_d;
`endif

            assign s_ready_core = ready_en_q && in_ready;

            // The closing input beat bypasses the accumulator straight into the output register.
            always_comb begin
                acc_data_d = acc_data_q;
                acc_keep_d = acc_keep_q;
                acc_user_d = acc_user_q;
                seg_d      = seg_q;
                state_d    = state_q;
                take       = s_axis_tvalid && s_ready_core;
                closing    = (seg_q == SEG_W'(N - 1)) || s_axis_tlast;
                in_data    = acc_data_q;
                in_keep    = acc_keep_q;
                in_data[seg_q*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
                in_keep[seg_q*S_LANES +: S_LANES]           = s_keep_eff;
                in_user    = acc_user_q | s_user_eff;
                in_last    = s_axis_tlast;
                in_valid   = take && closing;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                acc_id_d   = acc_id_q;
                acc_dest_d = acc_dest_q;
                in_id      = (state_q == IDLE) ? s_axis_tid : acc_id_q;
                in_dest    = (state_q == IDLE) ? s_axis_tdest : acc_dest_q;
`endif
                if (take) begin
                    if (closing) begin
                        acc_data_d = '0;
                        acc_keep_d = '0;
                        acc_user_d = '0;
                        seg_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        acc_data_d = in_data;
                        acc_keep_d = in_keep;
                        acc_user_d = in_user;
                        seg_d      = seg_q + 1'b1;
                        state_d    = ACTIVE;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                        acc_id_d   = in_id;
                        acc_dest_d = in_dest;
`endif
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_data_q <= '0;
                    acc_keep_q <= '0;
                    acc_user_q <= '0;
                    seg_q      <= '0;
                    state_q    <= IDLE;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                    acc_id_q   <= '0;
                    acc_dest_q <= '0;
`endif
                end else begin
                    acc_data_q <= acc_data_d;
                    acc_keep_q <= acc_keep_d;
                    acc_user_q <= acc_user_d;
                    seg_q      <= seg_d;
                    state_q    <= state_d;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                    acc_id_q   <= acc_id_d;
                    acc_dest_q <= acc_dest_d;
`endif
                end
            end
        end else begin : g_down
            logic [S_DATA_WIDTH-1:0] word_q, word_d;
            logic [S_LANES-1:0]      wkeep_q, wkeep_d;
            logic                    wlast_q, wlast_d;
            logic [USER_WIDTH-1:0]   wuser_q, wuser_d;
            logic [SEG_W-1:0]        seg_q, seg_d, last_seg_q, last_seg_d, s_last_seg, nseg;
            state_t                  state_q, state_d;
            logic                    take, out_hs, final_hs;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
            logic [ID_WIDTH-1:0]     wid_q, wid_d;
            logic [DEST_WIDTH-1:0]   wdest_q, wdest_d;
`endif

            assign out_hs       = (state_q == ACTIVE) && m_axis_tvalid && m_axis_tready;
            assign final_hs     = out_hs && (seg_q == last_seg_q);
            assign s_ready_core = ready_en_q && ((state_q == IDLE) || final_hs);
            assign take         = s_axis_tvalid && s_ready_core;
            assign nseg         = seg_q + 1'b1;

            // Highest segment holding a kept byte; emission stops there.
            always_comb begin
                s_last_seg = '0;
                for (int i = 0; i < N; i++) begin
                    if (|s_keep_eff[i*M_LANES +: M_LANES]) s_last_seg = SEG_W'(i);
                end
            end

            always_comb begin
                word_d     = word_q;
                wkeep_d    = wkeep_q;
                wlast_d    = wlast_q;
                wuser_d    = wuser_q;
                seg_d      = seg_q;
                last_seg_d = last_seg_q;
                state_d    = state_q;
                in_valid   = 1'b0;
                in_data    = word_q[nseg*M_DATA_WIDTH +: M_DATA_WIDTH];
                in_keep    = wkeep_q[nseg*M_LANES +: M_LANES];
                in_last    = wlast_q && (nseg == last_seg_q);
                in_user    = wuser_q;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                wid_d      = wid_q;
                wdest_d    = wdest_q;
                in_id      = wid_q;
                in_dest    = wdest_q;
`endif
                if (take && (|s_keep_eff)) begin
                    in_valid   = 1'b1;
                    in_data    = s_axis_tdata[0 +: M_DATA_WIDTH];
                    in_keep    = s_keep_eff[0 +: M_LANES];
                    in_last    = s_axis_tlast && (s_last_seg == '0);
                    in_user    = s_user_eff;
                    word_d     = s_axis_tdata;
                    wkeep_d    = s_keep_eff;
                    wlast_d    = s_axis_tlast;
                    wuser_d    = s_user_eff;
                    seg_d      = '0;
                    last_seg_d = s_last_seg;
                    state_d    = ACTIVE;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                    in_id      = s_axis_tid;
                    in_dest    = s_axis_tdest;
                    wid_d      = s_axis_tid;
                    wdest_d    = s_axis_tdest;
`endif
                end else if (final_hs) begin
                    state_d = IDLE;
                end else if (out_hs) begin
                    in_valid = 1'b1;
                    seg_d    = nseg;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q     <= '0;
                    wkeep_q    <= '0;
                    wlast_q    <= 1'b0;
                    wuser_q    <= '0;
                    seg_q      <= '0;
                    last_seg_q <= '0;
                    state_q    <= IDLE;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                    wid_q      <= '0;
                    wdest_q    <= '0;
`endif
                end else begin
                    word_q     <= word_d;
                    wkeep_q    <= wkeep_d;
                    wlast_q    <= wlast_d;
                    wuser_q    <= wuser_d;
                    seg_q      <= seg_d;
                    last_seg_q <= last_seg_d;
                    state_q    <= state_d;
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
                    wid_q      <= wid_d;
                    wdest_q    <= wdest_d;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_width_adapter.sv
// Directed bench for axis_width_adapter: an 8->32 upsizer and a 32->8 downsizer side by side.
module tb_axis_width_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic [7:0]  up_s_tdata;
    logic [0:0]  up_s_tkeep;
    logic        up_s_tvalid, up_s_tready, up_s_tlast;
    logic [7:0]  up_s_tid, up_s_tdest;
    logic [0:0]  up_s_tuser;
    logic [31:0] up_m_tdata;
    logic [3:0]  up_m_tkeep;
    logic        up_m_tvalid, up_m_tready, up_m_tlast;
    logic [7:0]  up_m_tid, up_m_tdest;
    logic [0:0]  up_m_tuser;

    logic [31:0] dn_s_tdata;
    logic [3:0]  dn_s_tkeep;
    logic        dn_s_tvalid, dn_s_tready, dn_s_tlast;
    logic [7:0]  dn_s_tid, dn_s_tdest;
    logic [0:0]  dn_s_tuser;
    logic [7:0]  dn_m_tdata;
    logic [0:0]  dn_m_tkeep;
    logic        dn_m_tvalid, dn_m_tready, dn_m_tlast;
    logic [7:0]  dn_m_tid, dn_m_tdest;
    logic [0:0]  dn_m_tuser;

    axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32)) u_up (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(up_s_tdata), .s_axis_tkeep(up_s_tkeep), .s_axis_tvalid(up_s_tvalid),
        .s_axis_tready(up_s_tready), .s_axis_tlast(up_s_tlast), .s_axis_tid(up_s_tid),
        .s_axis_tdest(up_s_tdest), .s_axis_tuser(up_s_tuser),
        .m_axis_tdata(up_m_tdata), .m_axis_tkeep(up_m_tkeep), .m_axis_tvalid(up_m_tvalid),
        .m_axis_tready(up_m_tready), .m_axis_tlast(up_m_tlast), .m_axis_tid(up_m_tid),
        .m_axis_tdest(up_m_tdest), .m_axis_tuser(up_m_tuser)
    );

    axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) u_dn (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(dn_s_tdata), .s_axis_tkeep(dn_s_tkeep), .s_axis_tvalid(dn_s_tvalid),
        .s_axis_tready(dn_s_tready), .s_axis_tlast(dn_s_tlast), .s_axis_tid(dn_s_tid),
        .s_axis_tdest(dn_s_tdest), .s_axis_tuser(dn_s_tuser),
        .m_axis_tdata(dn_m_tdata), .m_axis_tkeep(dn_m_tkeep), .m_axis_tvalid(dn_m_tvalid),
        .m_axis_tready(dn_m_tready), .m_axis_tlast(dn_m_tlast), .m_axis_tid(dn_m_tid),
        .m_axis_tdest(dn_m_tdest), .m_axis_tuser(dn_m_tuser)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (up_m_tvalid !== 1'b0 || up_s_tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_up got valid=%b ready=%b expected 0 0", up_m_tvalid, up_s_tready);
        end
        checks++;
        if (dn_m_tvalid !== 1'b0 || dn_s_tready !== 1'b0 || dn_m_tdata !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_dn got valid=%b ready=%b data=%h expected 0 0 00", dn_m_tvalid, dn_s_tready, dn_m_tdata);
        end
        checks++;
        if (up_m_tdata !== 32'h0 || up_m_tkeep !== 4'h0 || up_m_tlast !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_up_regs got data=%h keep=%h last=%b expected 0", up_m_tdata, up_m_tkeep, up_m_tlast);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (up_s_tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_early got %b expected 0", up_s_tready);
        end
        step();
        checks++;
        if (up_s_tready !== 1'b1 || dn_s_tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready_rise got up=%b dn=%b expected 1 1", up_s_tready, dn_s_tready);
        end
    endtask

    task automatic test_upsize_full();
        logic [7:0] bytes [4];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        up_m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            up_s_tvalid = 1'b1;
            up_s_tdata  = bytes[i];
            up_s_tlast  = (i == 3);
            up_s_tuser  = (i == 2) ? 1'b1 : 1'b0;
            up_s_tid    = (i == 0) ? 8'h5A : 8'h00;
            #1;
            checks++;
            if (up_s_tready !== 1'b1 || up_m_tvalid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL up_full_fill%0d got ready=%b valid=%b expected 1 0", i, up_s_tready, up_m_tvalid);
            end
            step();
        end
        up_s_tvalid = 1'b0;
        up_s_tuser  = 1'b0;
        checks++;
        if (up_m_tvalid !== 1'b1 || up_m_tdata !== 32'h44332211 || up_m_tkeep !== 4'hF || up_m_tlast !== 1'b1) begin
            failures++;
            $display("[TB] FAIL up_full_beat got v=%b d=%h k=%h l=%b expected 1 44332211 f 1", up_m_tvalid, up_m_tdata, up_m_tkeep, up_m_tlast);
        end
        checks++;
        if (up_m_tuser !== 1'b1) begin
            failures++;
            $display("[TB] FAIL up_full_user got %b expected 1", up_m_tuser);
        end
`ifdef AXIS_WIDTH_ADAPTER_ID_DEST_EN
        checks++;
        if (up_m_tid !== 8'h5A) begin
            failures++;
            $display("[TB] FAIL up_full_tid got %h expected 5a", up_m_tid);
        end
`else
        checks++;
        if (up_m_tid !== 8'h00 || up_m_tdest !== 8'h00) begin
            failures++;
            $display("[TB] FAIL up_full_tid got %h/%h expected 00/00", up_m_tid, up_m_tdest);
        end
`endif
        step();
        checks++;
        if (up_m_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL up_full_drain got valid=%b expected 0", up_m_tvalid);
        end
    endtask

    task automatic test_upsize_short();
        logic [7:0] bytes [6];
        logic       lasts [6];
        bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'h01;
        bytes[3] = 8'h02; bytes[4] = 8'h03; bytes[5] = 8'h04;
        for (int i = 0; i < 6; i++) lasts[i] = (i == 1);
        up_m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            up_s_tvalid = 1'b1;
            up_s_tdata  = bytes[i];
            up_s_tlast  = lasts[i];
            step();
            if (i == 1) begin
                checks++;
                if (up_m_tvalid !== 1'b1 || up_m_tdata !== 32'h0000BBAA || up_m_tkeep !== 4'h3 || up_m_tlast !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL up_short_beat got v=%b d=%h k=%h l=%b expected 1 0000bbaa 3 1", up_m_tvalid, up_m_tdata, up_m_tkeep, up_m_tlast);
                end
            end
            if (i == 2 || i == 4) begin
                checks++;
                if (up_m_tvalid !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL up_short_gap%0d got valid=%b expected 0", i, up_m_tvalid);
                end
            end
        end
        up_s_tvalid = 1'b0;
        checks++;
        if (up_m_tvalid !== 1'b1 || up_m_tdata !== 32'h04030201 || up_m_tkeep !== 4'hF || up_m_tlast !== 1'b0) begin
            failures++;
            $display("[TB] FAIL up_fresh_beat got v=%b d=%h k=%h l=%b expected 1 04030201 f 0", up_m_tvalid, up_m_tdata, up_m_tkeep, up_m_tlast);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [4];
        bytes[0] = 8'h51; bytes[1] = 8'h52; bytes[2] = 8'h53; bytes[3] = 8'h54;
        up_m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_s_tvalid = 1'b1;
            up_s_tdata  = bytes[i];
            up_s_tlast  = 1'b0;
            step();
        end
        up_s_tdata = 8'h61;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (up_s_tready !== 1'b0 || up_m_tvalid !== 1'b1 || up_m_tdata !== 32'h54535251 || up_m_tlast !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got r=%b v=%b d=%h l=%b expected 0 1 54535251 0", c, up_s_tready, up_m_tvalid, up_m_tdata, up_m_tlast);
            end
            step();
        end
        up_m_tready = 1'b1;
        #1;
        checks++;
        if (up_s_tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_release got ready=%b expected 1", up_s_tready);
        end
        step();
        for (int i = 2; i <= 4; i++) begin
            up_s_tdata = 8'h60 + 8'(i);
            up_s_tlast = (i == 4);
            step();
        end
        up_s_tvalid = 1'b0;
        checks++;
        if (up_m_tvalid !== 1'b1 || up_m_tdata !== 32'h64636261 || up_m_tlast !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_next_beat got v=%b d=%h l=%b expected 1 64636261 1", up_m_tvalid, up_m_tdata, up_m_tlast);
        end
        step();
    endtask

    task automatic test_reset_midframe();
        up_m_tready = 1'b1;
        up_s_tvalid = 1'b1;
        up_s_tlast  = 1'b0;
        up_s_tdata  = 8'h71;
        step();
        up_s_tdata  = 8'h72;
        step();
        up_s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (up_m_tvalid !== 1'b0 || up_s_tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid got valid=%b ready=%b expected 0 0", up_m_tvalid, up_s_tready);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            up_s_tvalid = 1'b1;
            up_s_tdata  = 8'hA0 + 8'(i);
            up_s_tlast  = (i == 4);
            step();
        end
        up_s_tvalid = 1'b0;
        checks++;
        if (up_m_tvalid !== 1'b1 || up_m_tdata !== 32'hA4A3A2A1 || up_m_tkeep !== 4'hF || up_m_tlast !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_clean_beat got v=%b d=%h k=%h l=%b expected 1 a4a3a2a1 f 1", up_m_tvalid, up_m_tdata, up_m_tkeep, up_m_tlast);
        end
        step();
    endtask

    task automatic test_downsize_full();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        dn_m_tready = 1'b1;
        dn_s_tvalid = 1'b1;
        dn_s_tdata  = 32'h44332211;
        dn_s_tkeep  = 4'hF;
        dn_s_tlast  = 1'b1;
        dn_s_tuser  = 1'b0;
        step();
        dn_s_tvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dn_m_tvalid !== 1'b1 || dn_m_tdata !== exp[k] || dn_m_tlast !== (k == 3) || dn_s_tready !== (k == 3)) begin
                failures++;
                $display("[TB] FAIL dn_full_seg%0d got v=%b d=%h l=%b r=%b expected 1 %h %b %b", k, dn_m_tvalid, dn_m_tdata, dn_m_tlast, dn_s_tready, exp[k], k == 3, k == 3);
            end
            step();
        end
        checks++;
        if (dn_m_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dn_full_idle got valid=%b expected 0", dn_m_tvalid);
        end
    endtask

    task automatic test_downsize_partial();
        dn_m_tready = 1'b1;
        dn_s_tvalid = 1'b1;
        dn_s_tdata  = 32'hDDCCBBAA;
        dn_s_tkeep  = 4'h3;
        dn_s_tlast  = 1'b1;
        dn_s_tuser  = 1'b1;
        step();
        dn_s_tvalid = 1'b0;
        dn_s_tuser  = 1'b0;
        checks++;
        if (dn_m_tvalid !== 1'b1 || dn_m_tdata !== 8'hAA || dn_m_tlast !== 1'b0 || dn_m_tuser !== 1'b1 || dn_m_tkeep !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dn_part_seg0 got v=%b d=%h l=%b u=%b k=%b expected 1 aa 0 1 1", dn_m_tvalid, dn_m_tdata, dn_m_tlast, dn_m_tuser, dn_m_tkeep);
        end
        step();
        checks++;
        if (dn_m_tvalid !== 1'b1 || dn_m_tdata !== 8'hBB || dn_m_tlast !== 1'b1 || dn_m_tuser !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dn_part_seg1 got v=%b d=%h l=%b u=%b expected 1 bb 1 1", dn_m_tvalid, dn_m_tdata, dn_m_tlast, dn_m_tuser);
        end
        step();
        checks++;
        if (dn_m_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dn_part_stop got valid=%b expected 0", dn_m_tvalid);
        end
        dn_s_tvalid = 1'b1;
        dn_s_tdata  = 32'h12345678;
        dn_s_tkeep  = 4'h0;
        #1;
        checks++;
        if (dn_s_tready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dn_zero_accept got ready=%b expected 1", dn_s_tready);
        end
        step();
        dn_s_tvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (dn_m_tvalid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL dn_zero_quiet%0d got valid=%b expected 0", c, dn_m_tvalid);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        logic [3:0]  keeps [2];
        logic        lasts [2];
        logic [7:0]  exp   [7];
        logic [7:0]  pat;
        logic [7:0]  held_data;
        logic        held, hs_in, hs_out;
        int          in_idx, out_idx;
        words[0] = 32'h04030201; keeps[0] = 4'hF; lasts[0] = 1'b0;
        words[1] = 32'h08070605; keeps[1] = 4'h7; lasts[1] = 1'b1;
        for (int i = 0; i < 7; i++) exp[i] = 8'(i + 1);
        pat       = 8'b1011_0111;
        held      = 1'b0;
        held_data = 8'h00;
        in_idx    = 0;
        out_idx   = 0;
        dn_s_tvalid = 1'b1;
        dn_s_tdata  = words[0];
        dn_s_tkeep  = keeps[0];
        dn_s_tlast  = lasts[0];
        for (int c = 0; c < 60 && out_idx < 7; c++) begin
            dn_m_tready = pat[c % 8];
            #1;
            hs_in  = dn_s_tvalid && dn_s_tready;
            hs_out = dn_m_tvalid && dn_m_tready;
            if (held) begin
                checks++;
                if (dn_m_tvalid !== 1'b1 || dn_m_tdata !== held_data) begin
                    failures++;
                    $display("[TB] FAIL b2b_stable got v=%b d=%h expected 1 %h", dn_m_tvalid, dn_m_tdata, held_data);
                end
            end
            if (hs_out) begin
                checks++;
                if (dn_m_tdata !== exp[out_idx] || dn_m_tlast !== (out_idx == 6)) begin
                    failures++;
                    $display("[TB] FAIL b2b_beat%0d got d=%h l=%b expected %h %b", out_idx, dn_m_tdata, dn_m_tlast, exp[out_idx], out_idx == 6);
                end
                out_idx++;
            end
            held      = dn_m_tvalid && !dn_m_tready;
            held_data = dn_m_tdata;
            step();
            if (hs_in) begin
                in_idx++;
                if (in_idx < 2) begin
                    dn_s_tdata = words[in_idx];
                    dn_s_tkeep = keeps[in_idx];
                    dn_s_tlast = lasts[in_idx];
                end else begin
                    dn_s_tvalid = 1'b0;
                end
            end
        end
        checks++;
        if (out_idx != 7 || in_idx != 2) begin
            failures++;
            $display("[TB] FAIL b2b_count got out=%0d in=%0d expected 7 2", out_idx, in_idx);
        end
        dn_m_tready = 1'b1;
        step();
        checks++;
        if (dn_m_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_extra got valid=%b expected 0", dn_m_tvalid);
        end
    endtask

    initial begin
        up_s_tdata = '0; up_s_tkeep = 1'b1; up_s_tvalid = 1'b0; up_s_tlast = 1'b0;
        up_s_tid = '0; up_s_tdest = '0; up_s_tuser = '0; up_m_tready = 1'b0;
        dn_s_tdata = '0; dn_s_tkeep = '0; dn_s_tvalid = 1'b0; dn_s_tlast = 1'b0;
        dn_s_tid = '0; dn_s_tdest = '0; dn_s_tuser = '0; dn_m_tready = 1'b0;
        test_reset();
        test_upsize_full();
        test_upsize_short();
        test_backpressure();
        test_reset_midframe();
        test_downsize_full();
        test_downsize_partial();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
